// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit (8E1).
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8,
   parameter int FIFO_AW      = 3
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             wr_valid,
   input  logic [7:0]       wr_data,
   output logic             wr_ready,
   output logic             uart_tx,
   output logic             busy,
   output logic [FIFO_AW:0] fifo_count
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [7:0]         mem_d [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wptr_q, wptr_d;
   logic [FIFO_AW-1:0] rptr_q, rptr_d;
   logic [FIFO_AW:0]   count_q, count_d;

   // Transmitter state
   state_t             state_q, state_d;
   logic               tx_q, tx_d;
   logic [7:0]         shift_q, shift_d;
   logic [2:0]         bit_q, bit_d;
   logic [BW-1:0]      baud_q, baud_d;
`ifdef UART_TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               baud_end;
   logic [7:0]         head;

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign push     = wr_valid && !full;
   assign baud_end = (baud_q == BAUD_LAST);
   assign head     = mem_q[rptr_q];

   assign wr_ready   = ~full;
   assign uart_tx    = tx_q;
   assign busy       = (state_q != IDLE) || !empty;
   assign fifo_count = count_q;

   // FIFO next state: push at the tail, pop from the head, track occupancy
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[wptr_q] = wr_data;
         wptr_d        = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO registers; reset discards any buffered bytes
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Frame sequencer: every non-idle state is timed by the baud counter
   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      baud_d   = baud_q;
      pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop      = 1'b1;
               shift_d  = head;
`ifdef UART_TX_PARITY_EN
               parity_d = ^head;
`endif
               tx_d     = 1'b0;
               baud_d   = '0;
               state_d  = START;
            end
         end
         START: begin
            if (baud_end) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_end) begin
               tx_d    = 1'b1;
               baud_d  = '0;
               state_d = STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (!empty) begin
                  pop      = 1'b1;
                  shift_d  = head;
`ifdef UART_TX_PARITY_EN
                  parity_d = ^head;
`endif
                  tx_d     = 1'b0;
                  state_d  = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers; reset truncates a frame and forces the line high
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q  <= IDLE;
         tx_q     <= 1'b1;
         shift_q  <= '0;
         bit_q    <= '0;
         baud_q   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         baud_q   <= baud_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule
